// File: rtl/pim_ram_pkg.sv
// -----------------------------------------------------------------------------
// pim_ram_pkg
// Shared types and constants for the on-chip RAM sharing logic.
//   RAM_AW / RAM_DW / RAM_BE_W : geometry of the single-port RAM IP
//   arb_state_t               : arbiter FSM states
//   ram_req_t                 : one requester's command as seen by the RAM
// -----------------------------------------------------------------------------
package pim_ram_pkg;

    localparam int RAM_AW   = 10;
    localparam int RAM_DW   = 32;
    localparam int RAM_BE_W = 4;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } arb_state_t;

    typedef struct packed {
        logic                we;
        logic [RAM_AW-1:0]   addr;
        logic [RAM_DW-1:0]   wdata;
        logic [RAM_BE_W-1:0] be;
    } ram_req_t;

endpackage

// File: rtl/ram_port_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant logic. The search starts at ptr and
// wraps, so the requester at ptr has top priority. The pointer register itself
// is owned by the parent.
//   req  in  N    request vector
//   ptr  in  IW   index with highest priority this cycle
//   gnt  out N    one-hot grant (all zero when nothing requests)
//   idx  out IW   binary index of the granted requester
//   any  out 1    at least one requester was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Walk the requesters starting at ptr; the first one found wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = 0; off < N; off++) begin
            cand = IW'((int'(ptr) + off) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port RAM IP between NREQ requesters with round-robin
// arbitration, a valid/ready request handshake and one outstanding read.
//   clk, reset          clock / async active-high reset
//   req_valid/we/addr/wdata/be   per-requester command (flattened vectors)
//   req_ready           one-hot, command accepted and issued this cycle
//   rsp_valid           one-hot 1-cycle pulse, rsp_rdata valid for that requester
//   rsp_rdata           registered read data shared by all requesters
//   ram_addr/wdata/wen/rden/byteena   command to the RAM IP
//   ram_rdata           read data from the RAM IP (RD_LAT edges after issue)
// -----------------------------------------------------------------------------
module ram_port_arbiter
    import pim_ram_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int AW     = RAM_AW,
    parameter int DW     = RAM_DW,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*4-1:0]      req_be,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DW-1:0]          rsp_rdata,
    output logic [AW-1:0]          ram_addr,
    output logic [DW-1:0]          ram_wdata,
    output logic                   ram_wen,
    output logic                   ram_rden,
    output logic [3:0]             ram_byteena,
    input  logic [DW-1:0]          ram_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t    state, state_next;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [1:0]    cnt;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            issue;
    logic            issue_rd;
    logic [IW-1:0]   ptr_next;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];
    logic [3:0]      be_arr    [NREQ];
    ram_req_t        sel;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Unflatten the requester buses and pick the granted requester's command.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*AW +: AW];
            wdata_arr[i] = req_wdata[i*DW +: DW];
            be_arr[i]    = req_be[i*4 +: 4];
        end
        sel.we    = req_we[gnt_idx];
        sel.addr  = addr_arr[gnt_idx];
        sel.wdata = wdata_arr[gnt_idx];
        sel.be    = be_arr[gnt_idx];
    end

    // Grants are only possible in IDLE; reset suppresses them so the RAM
    // sees a quiet bus while reset is held.
    assign issue    = (state == IDLE) && gnt_any && !reset;
    assign issue_rd = issue && !sel.we;
    assign ptr_next = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Next state and RAM command. The bus is driven with zeros whenever
    // nothing is issued, including the whole read wait.
    always_comb begin
        state_next  = state;
        req_ready   = '0;
        ram_addr    = '0;
        ram_wdata   = '0;
        ram_wen     = 1'b0;
        ram_rden    = 1'b0;
        ram_byteena = '0;
        case (state)
            IDLE: begin
                if (issue) begin
                    req_ready = gnt;
                    ram_addr  = sel.addr;
                    ram_wdata = sel.wdata;
                    if (sel.we) begin
                        ram_wen     = 1'b1;
                        ram_byteena = sel.be;
                    end else begin
                        ram_rden    = 1'b1;
                        ram_byteena = 4'hF;
                        state_next  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == 2'd0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, pointer and read bookkeeping. The response is captured on the
    // same edge that returns the FSM to IDLE, so a new grant can overlap the
    // rsp_valid cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= '0;
            if (issue) begin
                ptr <= ptr_next;
            end
            if (issue_rd) begin
                owner <= gnt_idx;
                cnt   <= 2'(RD_LAT - 1);
            end
            if (state == RD_WAIT) begin
                if (cnt == 2'd0) begin
                    rsp_rdata        <= ram_rdata;
                    rsp_valid[owner] <= 1'b1;
                end else begin
                    cnt <= cnt - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter. Two instances share the requester
// inputs: one with RD_LAT=1 and one with RD_LAT=3, each with its own small
// byte-enabled RAM model. Inputs are driven 1 time unit after the rising edge
// and outputs sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_ram_port_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [19:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;

    logic [1:0]  ready1, rspv1, ready3, rspv3;
    logic [31:0] rspd1, wdata1, rdata1, rspd3, wdata3, rdata3;
    logic [9:0]  addr1, addr3;
    logic        wen1, rden1, wen3, rden3;
    logic [3:0]  be1, be3;

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] pipe3 [0:2];

    int assertCount = 0;
    int failCount   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter #(.NREQ(2), .AW(10), .DW(32), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(ready1), .rsp_valid(rspv1), .rsp_rdata(rspd1),
        .ram_addr(addr1), .ram_wdata(wdata1), .ram_wen(wen1), .ram_rden(rden1),
        .ram_byteena(be1), .ram_rdata(rdata1)
    );

    ram_port_arbiter #(.NREQ(2), .AW(10), .DW(32), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(ready3), .rsp_valid(rspv3), .rsp_rdata(rspd3),
        .ram_addr(addr3), .ram_wdata(wdata3), .ram_wen(wen3), .ram_rden(rden3),
        .ram_byteena(be3), .ram_rdata(rdata3)
    );

    // RAM model for the RD_LAT=1 instance: data valid right after the issue edge.
    always @(posedge clk) begin
        if (wen1) begin
            for (int b = 0; b < 4; b++)
                if (be1[b]) mem1[addr1][b*8 +: 8] <= wdata1[b*8 +: 8];
        end
        if (rden1) rdata1 <= mem1[addr1];
    end

    // RAM model for the RD_LAT=3 instance: three-stage read pipeline.
    always @(posedge clk) begin
        if (wen3) begin
            for (int b = 0; b < 4; b++)
                if (be3[b]) mem3[addr3][b*8 +: 8] <= wdata3[b*8 +: 8];
        end
        if (rden3) pipe3[0] <= mem3[addr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign rdata3 = pipe3[2];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic we,
                                 input logic [9:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be);
        req_valid[idx]           = valid;
        req_we[idx]              = we;
        req_addr[idx*10 +: 10]   = addr;
        req_wdata[idx*32 +: 32]  = wdata;
        req_be[idx*4 +: 4]       = be;
    endtask

    task automatic clearReq();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Quiet-bus check for one instance (d = 1 or 3).
    task automatic checkQuiet(input string tag, input int d);
        if (d == 1) begin
            checkOutput({tag, "_ready1"}, ready1, 0);
            checkOutput({tag, "_rspv1"},  rspv1,  0);
            checkOutput({tag, "_wen1"},   wen1,   0);
            checkOutput({tag, "_rden1"},  rden1,  0);
            checkOutput({tag, "_addr1"},  addr1,  0);
            checkOutput({tag, "_wdata1"}, wdata1, 0);
            checkOutput({tag, "_be1"},    be1,    0);
        end else begin
            checkOutput({tag, "_ready3"}, ready3, 0);
            checkOutput({tag, "_rspv3"},  rspv3,  0);
            checkOutput({tag, "_wen3"},   wen3,   0);
            checkOutput({tag, "_rden3"},  rden3,  0);
            checkOutput({tag, "_addr3"},  addr3,  0);
            checkOutput({tag, "_wdata3"}, wdata3, 0);
            checkOutput({tag, "_be3"},    be3,    0);
        end
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clearReq();
        pipe3[0] = '0; pipe3[1] = '0; pipe3[2] = '0;
        rdata1 = '0;

        // Reset state of both instances.
        step(); step(); #1;
        checkQuiet("rst", 1);
        checkQuiet("rst", 3);
        checkOutput("rst_rspd1", rspd1, 0);
        checkOutput("rst_rspd3", rspd3, 0);
        step();
        reset = 1'b0;
        step();

        // Test 1: single full-word write from req0.
        applyStimulus(0, 1'b1, 1'b1, 10'h004, 32'hABCD1234, 4'hF);
        #1;
        checkOutput("t1_ready", ready1, 2'b01);
        checkOutput("t1_wen",   wen1,   1);
        checkOutput("t1_rden",  rden1,  0);
        checkOutput("t1_addr",  addr1,  10'h004);
        checkOutput("t1_wdata", wdata1, 32'hABCD1234);
        checkOutput("t1_be",    be1,    4'hF);
        step();
        clearReq();
        #1;
        checkOutput("t1_mem", mem1[4], 32'hABCD1234);
        checkQuiet("t1_idle", 1);

        // Test 2: read with RD_LAT=1; req1 write is held off during the wait.
        mem1[4] = 32'h87654321;
        step();
        applyStimulus(0, 1'b1, 1'b0, 10'h004, 32'h0, 4'h0);
        #1;
        checkOutput("t2_ready", ready1, 2'b01);
        checkOutput("t2_rden",  rden1,  1);
        checkOutput("t2_wen",   wen1,   0);
        checkOutput("t2_be",    be1,    4'hF);
        checkOutput("t2_addr",  addr1,  10'h004);
        step();
        clearReq();
        applyStimulus(1, 1'b1, 1'b1, 10'h008, 32'h00000055, 4'hF);
        #1;
        checkOutput("t2_wait_ready", ready1, 2'b00);
        checkOutput("t2_wait_wen",   wen1,   0);
        checkOutput("t2_wait_rden",  rden1,  0);
        checkOutput("t2_wait_rspv",  rspv1,  2'b00);
        step();
        #1;
        checkOutput("t2_rspv",       rspv1,  2'b01);
        checkOutput("t2_rspd",       rspd1,  32'h87654321);
        checkOutput("t2_overlap_rdy", ready1, 2'b10);
        checkOutput("t2_overlap_wen", wen1,   1);
        checkOutput("t2_overlap_adr", addr1,  10'h008);
        step();
        clearReq();
        #1;
        checkOutput("t2_rspv_pulse", rspv1, 2'b00);
        checkOutput("t2_rspd_hold",  rspd1, 32'h87654321);

        // Test 3: both requesters stream writes; grants alternate from req0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 10'h010, 32'h11110000, 4'hF);
        applyStimulus(1, 1'b1, 1'b1, 10'h020, 32'h22220000, 4'hF);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("t3_ready%0d", k), ready1, (k % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput($sformatf("t3_addr%0d", k),  addr1,  (k % 2 == 0) ? 10'h010 : 10'h020);
            step();
        end
        clearReq();

        // Test 4: req1 read wins over pending req0 write; req0 stalls RD_LAT cycles.
        applyStimulus(0, 1'b1, 1'b1, 10'h030, 32'h33333333, 4'hF);
        #1;
        checkOutput("t4_pre_ready", ready1, 2'b01);
        step();
        applyStimulus(1, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
        #1;
        checkOutput("t4_ready", ready1, 2'b10);
        checkOutput("t4_rden",  rden1,  1);
        checkOutput("t4_addr",  addr1,  10'h020);
        step();
        applyStimulus(1, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        #1;
        checkOutput("t4_stall_ready", ready1, 2'b00);
        checkOutput("t4_stall_wen",   wen1,   0);
        step();
        #1;
        checkOutput("t4_rspv",  rspv1,  2'b10);
        checkOutput("t4_rspd",  rspd1,  32'h22220000);
        checkOutput("t4_ready0", ready1, 2'b01);
        checkOutput("t4_wen",   wen1,   1);
        checkOutput("t4_waddr", addr1,  10'h030);
        step();
        clearReq();

        // Test 6: partial write then read back the merged word.
        mem1[10'h040] = 32'h11223344;
        applyStimulus(0, 1'b1, 1'b1, 10'h040, 32'h0000AB00, 4'b0010);
        #1;
        checkOutput("t6_ready", ready1, 2'b01);
        checkOutput("t6_wen",   wen1,   1);
        checkOutput("t6_be",    be1,    4'b0010);
        step();
        applyStimulus(0, 1'b1, 1'b0, 10'h040, 32'h0, 4'h0);
        #1;
        checkOutput("t6_rd_rden", rden1, 1);
        checkOutput("t6_rd_be",   be1,   4'hF);
        step();
        clearReq();
        #1;
        checkOutput("t6_wait_rspv", rspv1, 2'b00);
        step();
        #1;
        checkOutput("t6_rspv", rspv1, 2'b01);
        checkOutput("t6_rspd", rspd1, 32'h1122AB44);

        // Test 5: reset during a RD_LAT=3 read, then a fresh read.
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem3[10'h050] = 32'hCAFEF00D;
        applyStimulus(1, 1'b1, 1'b0, 10'h050, 32'h0, 4'h0);
        #1;
        checkOutput("t5_ready", ready3, 2'b10);
        checkOutput("t5_rden",  rden3,  1);
        step();
        clearReq();
        #1;
        checkOutput("t5_wait_ready", ready3, 2'b00);
        checkOutput("t5_wait_rspv",  rspv3,  2'b00);
        step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkQuiet($sformatf("t5_rst%0d", k), 3);
            checkOutput($sformatf("t5_rst_rspd%0d", k), rspd3, 0);
            step();
        end
        reset = 1'b0;
        #1;
        checkOutput("t5_post_rspv", rspv3, 2'b00);
        step();
        applyStimulus(1, 1'b1, 1'b0, 10'h050, 32'h0, 4'h0);
        #1;
        checkOutput("t5_new_ready", ready3, 2'b10);
        checkOutput("t5_new_rden",  rden3,  1);
        checkOutput("t5_new_addr",  addr3,  10'h050);
        step();
        clearReq();
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("t5_new_wait%0d", k), rspv3, 2'b00);
            step();
        end
        #1;
        checkOutput("t5_new_rspv", rspv3, 2'b10);
        checkOutput("t5_new_rspd", rspd3, 32'hCAFEF00D);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
